// File: rtl/dmac_write_engine.sv
// dmac_write_engine: drains burst metadata and data FIFOs into AXI AW/W bursts
// and tracks outstanding B responses, flagging error responses stickily.
module dmac_write_engine #(
   parameter int MAX_OUTSTANDING = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        meta_empty_i,
   input  logic [31:0] meta_awaddr_i,
   input  logic [3:0]  meta_awlen_i,
   output logic        meta_rden_o,
   input  logic        data_empty_i,
   input  logic [31:0] data_i,
   output logic        data_rden_o,
   output logic [31:0] awaddr_o,
   output logic [3:0]  awlen_o,
   output logic [2:0]  awsize_o,
   output logic [1:0]  awburst_o,
   output logic        awvalid_o,
   input  logic        awready_i,
   output logic [31:0] wdata_o,
   output logic [3:0]  wstrb_o,
   output logic        wlast_o,
   output logic        wvalid_o,
   input  logic        wready_i,
   input  logic        bvalid_i,
   input  logic [1:0]  bresp_i,
   output logic        bready_o,
   output logic        idle_o,
   output logic        err_o
);
   typedef enum logic [1:0] {S_IDLE, S_AW, S_W} state_t;

   state_t      state_q, state_d;
   logic [31:0] awaddr_q, awaddr_d;
   logic [3:0]  awlen_q, awlen_d, beat_cnt_q, beat_cnt_d, out_cnt_q, out_cnt_d;
   logic        err_q, err_d, aw_hs, b_hs;

   always_comb begin
      state_d     = state_q;
      awaddr_d    = awaddr_q;
      awlen_d     = awlen_q;
      beat_cnt_d  = beat_cnt_q;
      meta_rden_o = 1'b0;
      awvalid_o   = 1'b0;
      wvalid_o    = 1'b0;
      wlast_o     = 1'b0;
      data_rden_o = 1'b0;
      case (state_q)
         S_IDLE: if (!meta_empty_i && out_cnt_q < 4'(MAX_OUTSTANDING)) begin
            meta_rden_o = 1'b1;
            awaddr_d    = meta_awaddr_i;
            awlen_d     = meta_awlen_i;
            state_d     = S_AW;
         end
         S_AW: begin
            awvalid_o = 1'b1;
            if (awready_i) begin
               beat_cnt_d = awlen_q;
               state_d    = S_W;
            end
         end
         S_W: begin
            wvalid_o    = !data_empty_i;
            wlast_o     = beat_cnt_q == 4'd0;
            data_rden_o = !data_empty_i && wready_i;
            if (data_rden_o) begin
               beat_cnt_d = beat_cnt_q - 4'd1;
               if (wlast_o) state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
      aw_hs = awvalid_o && awready_i;
      b_hs  = bvalid_i;
      // a B with nothing outstanding is dropped and reported as an error
      out_cnt_d = out_cnt_q + {3'b0, aw_hs} - {3'b0, b_hs && out_cnt_q != 4'd0};
      err_d     = err_q || (b_hs && (out_cnt_q == 4'd0 || bresp_i != 2'b00));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         awaddr_q   <= '0;
         awlen_q    <= '0;
         beat_cnt_q <= '0;
         out_cnt_q  <= '0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         awaddr_q   <= awaddr_d;
         awlen_q    <= awlen_d;
         beat_cnt_q <= beat_cnt_d;
         out_cnt_q  <= out_cnt_d;
         err_q      <= err_d;
      end
   end

   assign awaddr_o  = awaddr_q;
   assign awlen_o   = awlen_q;
   assign awsize_o  = 3'b010;
   assign awburst_o = 2'b01;
   assign wdata_o   = data_i;
   assign wstrb_o   = 4'hF;
   assign bready_o  = 1'b1;
   assign err_o     = err_q;
   assign idle_o    = state_q == S_IDLE && meta_empty_i && out_cnt_q == 4'd0;
endmodule

// File: tb/tb_dmac_write_engine.sv
// tb_dmac_write_engine: FIFO and AXI slave models around the write engine; every burst
// queued predicts the AW it must produce and the W beats (data, wlast) it must stream.
module tb_dmac_write_engine;
   logic        clk = 1'b0, rst_n = 1'b0;
   logic        meta_empty_i = 1'b1, data_empty_i = 1'b1;
   logic [31:0] meta_awaddr_i = '0, data_i = '0;
   logic [3:0]  meta_awlen_i = '0;
   logic        awready_i = 1'b0, wready_i = 1'b0, bvalid_i = 1'b0;
   logic [1:0]  bresp_i = '0;
   logic        meta_rden_o, data_rden_o, awvalid_o, wlast_o, wvalid_o, bready_o, idle_o, err_o;
   logic [31:0] awaddr_o, wdata_o;
   logic [3:0]  awlen_o, wstrb_o;
   logic [2:0]  awsize_o;
   logic [1:0]  awburst_o;

   dmac_write_engine #(.MAX_OUTSTANDING(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .meta_empty_i(meta_empty_i), .meta_awaddr_i(meta_awaddr_i), .meta_awlen_i(meta_awlen_i),
      .meta_rden_o(meta_rden_o), .data_empty_i(data_empty_i), .data_i(data_i),
      .data_rden_o(data_rden_o), .awaddr_o(awaddr_o), .awlen_o(awlen_o), .awsize_o(awsize_o),
      .awburst_o(awburst_o), .awvalid_o(awvalid_o), .awready_i(awready_i), .wdata_o(wdata_o),
      .wstrb_o(wstrb_o), .wlast_o(wlast_o), .wvalid_o(wvalid_o), .wready_i(wready_i),
      .bvalid_i(bvalid_i), .bresp_i(bresp_i), .bready_o(bready_o), .idle_o(idle_o), .err_o(err_o)
   );

   always #5 clk = ~clk;

   logic [35:0] mq[$], exp_aw[$], aw_obs[$];
   logic [32:0] exp_w[$], w_obs[$];
   logic [31:0] dq[$];
   logic [1:0]  bq[$], resp_plan[$];
   logic [35:0] aw_prev;
   logic [32:0] w_prev;
   int checks = 0, errors = 0, viol = 0, err_late = 0;
   int meta_pops, data_pops, stall_after, stall_left, stall_low, b_allow;
   bit rnd = 0, aw_block = 0, err_next = 0, aw_pend = 0, w_pend = 0;

   function automatic void clear();
      mq.delete(); dq.delete(); exp_aw.delete(); aw_obs.delete(); exp_w.delete(); w_obs.delete();
      bq.delete(); resp_plan.delete();
      meta_pops = 0; data_pops = 0; stall_after = -1; stall_left = 0; stall_low = 0; b_allow = -1;
   endfunction

   // reference model: each burst yields one AW and len+1 beats with wlast on the final one
   function automatic void add_burst(input logic [31:0] addr, input logic [3:0] len, input logic [1:0] resp);
      logic [31:0] d;
      mq.push_back({addr, len});
      exp_aw.push_back({addr, len});
      for (int i = 0; i <= int'(len); i++) begin
         d = $urandom;
         dq.push_back(d);
         exp_w.push_back({i == int'(len), d});
      end
      resp_plan.push_back(resp);
   endfunction

   function automatic int aw_diff();
      int n = (aw_obs.size() != exp_aw.size()) ? 1 : 0;
      if (n == 0) foreach (exp_aw[i]) if (aw_obs[i] !== exp_aw[i]) n++;
      return n;
   endfunction

   function automatic int w_diff();
      int n = (w_obs.size() != exp_w.size()) ? 1 : 0;
      if (n == 0) foreach (exp_w[i]) if (w_obs[i] !== exp_w[i]) n++;
      return n;
   endfunction

   task automatic cycle();
      bit stall;
      @(negedge clk);
      awready_i    = aw_block ? 1'b0 : (rnd ? 1'($urandom % 2) : 1'b1);
      wready_i     = rnd ? ($urandom % 4 != 0) : 1'b1;
      stall        = stall_after >= 0 && w_obs.size() == stall_after && stall_left > 0;
      data_empty_i = dq.size() == 0 || stall || (rnd && !w_pend && $urandom % 4 == 0);
      data_i       = dq.size() != 0 ? dq[0] : '0;
      meta_empty_i = mq.size() == 0;
      {meta_awaddr_i, meta_awlen_i} = mq.size() != 0 ? mq[0] : '0;
      bvalid_i     = bq.size() != 0 && b_allow != 0 && (!rnd || $urandom % 2 == 1);
      bresp_i      = bq.size() != 0 ? bq[0] : '0;
      #1;
      if (stall) begin
         stall_left--;
         if (!wvalid_o) stall_low++;
      end
      if (aw_pend && !(awvalid_o && {awaddr_o, awlen_o} == aw_prev)) viol++;
      if (w_pend && !(wvalid_o && {wlast_o, wdata_o} == w_prev)) viol++;
      if (err_next && err_o !== 1'b1) err_late++;
      aw_pend = awvalid_o && !awready_i;
      aw_prev = {awaddr_o, awlen_o};
      w_pend  = wvalid_o && !wready_i;
      w_prev  = {wlast_o, wdata_o};
      if (meta_rden_o) begin
         meta_pops++;
         if (mq.size() != 0) void'(mq.pop_front());
      end
      if (data_rden_o) begin
         data_pops++;
         if (dq.size() != 0) void'(dq.pop_front());
      end
      if (awvalid_o && awready_i) aw_obs.push_back({awaddr_o, awlen_o});
      if (wvalid_o && wready_i) begin
         w_obs.push_back({wlast_o, wdata_o});
         if (wlast_o && resp_plan.size() != 0) bq.push_back(resp_plan.pop_front());
      end
      if (bvalid_i) begin
         void'(bq.pop_front());
         if (bresp_i != 2'b00) err_next = 1;
         if (b_allow > 0) b_allow--;
      end
   endtask

   task automatic drain(input int budget, output bit ok);
      ok = 0;
      for (int k = 0; k < budget && !ok; k++) begin
         cycle();
         ok = idle_o && mq.size() == 0 && bq.size() == 0 && resp_plan.size() == 0;
      end
   endtask

   task automatic test_reset();
      clear();
      repeat (3) @(negedge clk);
      #1;
      checks++;
      if ({meta_rden_o, data_rden_o, awvalid_o, wvalid_o, wlast_o, err_o, idle_o} !== 7'b0000001 ||
          {awaddr_o, awlen_o} !== 36'h0) begin
         errors++;
         $display("FAIL reset_outputs: pop/valid/last/err/idle=%b aw=%h required 0000001 aw=0",
                  {meta_rden_o, data_rden_o, awvalid_o, wvalid_o, wlast_o, err_o, idle_o}, {awaddr_o, awlen_o});
      end
      @(negedge clk) rst_n = 1'b1;
      repeat (3) cycle();
      checks++;
      if ({awsize_o, awburst_o, wstrb_o, bready_o, idle_o} !== {3'b010, 2'b01, 4'hF, 1'b1, 1'b1}) begin
         errors++;
         $display("FAIL reset_constants: size=%b burst=%b strb=%h bready=%b idle=%b required 010 01 f 1 1",
                  awsize_o, awburst_o, wstrb_o, bready_o, idle_o);
      end
      checks++;
      if (meta_pops + data_pops != 0) begin
         errors++;
         $display("FAIL reset_no_pops: %0d pops while FIFOs empty, required 0", meta_pops + data_pops);
      end
   endtask

   task automatic test_single_burst();
      bit ok;
      clear();
      add_burst(32'h1000, 4'hF, 2'b00);
      drain(400, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL burst16_timeout: engine never returned idle, required idle"); end
      checks++;
      if (aw_diff() != 0) begin
         errors++;
         $display("FAIL burst16_aw: %0d AWs first=%h required 1 AW 00001000f", aw_obs.size(),
                  aw_obs.size() != 0 ? aw_obs[0] : 36'h0);
      end
      checks++;
      if (w_diff() != 0) begin
         errors++;
         $display("FAIL burst16_w: %0d beats observed, required %0d with wlast on beat 16 only", w_obs.size(), exp_w.size());
      end
      checks++;
      if (meta_pops != 1 || data_pops != 16 || idle_o !== 1'b1 || err_o !== 1'b0) begin
         errors++;
         $display("FAIL burst16_pops: meta=%0d data=%0d idle=%b err=%b required 1 16 1 0", meta_pops, data_pops, idle_o, err_o);
      end
   endtask

   task automatic test_len0();
      bit ok;
      clear();
      add_burst(32'h0000_2004, 4'h0, 2'b00);
      drain(100, ok);
      checks++;
      if (!ok || aw_diff() != 0 || w_diff() != 0) begin
         errors++;
         $display("FAIL len0_stream: ok=%0b aws=%0d beats=%0d required ok, 1 AW, 1 beat with wlast", ok, aw_obs.size(), w_obs.size());
      end
      checks++;
      if (meta_pops != 1 || data_pops != 1) begin
         errors++;
         $display("FAIL len0_pops: meta=%0d data=%0d required 1 1", meta_pops, data_pops);
      end
   endtask

   task automatic test_data_stall();
      bit ok;
      clear();
      add_burst(32'h0000_4000, 4'hF, 2'b00);
      stall_after = 5;
      stall_left  = 10;
      drain(400, ok);
      checks++;
      if (stall_low != 10) begin
         errors++;
         $display("FAIL stall_wvalid: wvalid low %0d of 10 empty cycles, required 10", stall_low);
      end
      checks++;
      if (!ok || aw_diff() != 0 || w_diff() != 0 || data_pops != 16) begin
         errors++;
         $display("FAIL stall_resume: ok=%0b beats=%0d wdiff=%0d pops=%0d required 16 in-order beats, 16 pops",
                  ok, w_obs.size(), w_diff(), data_pops);
      end
   endtask

   task automatic test_outstanding();
      bit ok;
      clear();
      b_allow = 0;
      for (int i = 0; i < 6; i++) add_burst(32'h0001_0000 + 32'(i * 64), 4'(i % 3), 2'b00);
      repeat (100) cycle();
      checks++;
      if (aw_obs.size() != 4 || meta_pops != 4) begin
         errors++;
         $display("FAIL outst_limit: aws=%0d pops=%0d with B withheld, required 4 4", aw_obs.size(), meta_pops);
      end
      b_allow = 1;
      repeat (40) cycle();
      checks++;
      if (aw_obs.size() != 5 || meta_pops != 5) begin
         errors++;
         $display("FAIL outst_release: aws=%0d pops=%0d after one B, required 5 5", aw_obs.size(), meta_pops);
      end
      b_allow = -1;
      drain(400, ok);
      checks++;
      if (!ok || aw_diff() != 0 || w_diff() != 0) begin
         errors++;
         $display("FAIL outst_drain: ok=%0b aws=%0d beats=%0d required 6 bursts in order", ok, aw_obs.size(), w_obs.size());
      end
   endtask

   task automatic test_bresp_err();
      bit ok;
      clear();
      checks++;
      if (err_o !== 1'b0) begin errors++; $display("FAIL err_initial: err=%b required 0", err_o); end
      add_burst(32'h0002_0000, 4'h3, 2'b00);
      add_burst(32'h0002_0100, 4'h2, 2'b10);
      add_burst(32'h0002_0200, 4'h4, 2'b00);
      drain(400, ok);
      checks++;
      if (err_late != 0 || err_o !== 1'b1) begin
         errors++;
         $display("FAIL err_sticky: late/cleared samples=%0d err=%b required 0 1", err_late, err_o);
      end
      checks++;
      if (!ok || aw_diff() != 0 || w_diff() != 0) begin
         errors++;
         $display("FAIL err_bursts: ok=%0b aws=%0d beats=%0d required all 3 bursts", ok, aw_obs.size(), w_obs.size());
      end
   endtask

   task automatic test_reset_mid();
      bit ok;
      clear();
      add_burst(32'h0003_0000, 4'hF, 2'b00);
      for (int k = 0; k < 200 && w_obs.size() < 7; k++) cycle();
      checks++;
      if (w_obs.size() != 7) begin errors++; $display("FAIL rst_mid_reach: %0d beats, required 7", w_obs.size()); end
      @(negedge clk);
      rst_n = 1'b0;
      aw_block = 1;
      clear();
      err_next = 0; aw_pend = 0; w_pend = 0;
      meta_empty_i = 1'b1;
      #1;
      checks++;
      if ({meta_rden_o, data_rden_o, awvalid_o, wvalid_o, wlast_o, err_o, idle_o} !== 7'b0000001 ||
          {awaddr_o, awlen_o} !== 36'h0) begin
         errors++;
         $display("FAIL rst_mid_outputs: pop/valid/last/err/idle=%b aw=%h required 0000001 aw=0",
                  {meta_rden_o, data_rden_o, awvalid_o, wvalid_o, wlast_o, err_o, idle_o}, {awaddr_o, awlen_o});
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (4) cycle();
      checks++;
      if (idle_o !== 1'b1 || meta_pops + data_pops != 0 || awvalid_o !== 1'b0) begin
         errors++;
         $display("FAIL rst_mid_idle: idle=%b pops=%0d awvalid=%b required 1 0 0", idle_o, meta_pops + data_pops, awvalid_o);
      end
      add_burst(32'h0003_1000, 4'h3, 2'b00);
      repeat (20) cycle();
      checks++;
      if (awvalid_o !== 1'b1 || aw_obs.size() != 0 || meta_pops != 1 || awaddr_o !== 32'h0003_1000) begin
         errors++;
         $display("FAIL aw_hold: awvalid=%b aws=%0d pops=%0d addr=%h required 1 0 1 00031000",
                  awvalid_o, aw_obs.size(), meta_pops, awaddr_o);
      end
      aw_block = 0;
      drain(200, ok);
      checks++;
      if (!ok || aw_diff() != 0 || w_diff() != 0 || err_o !== 1'b0) begin
         errors++;
         $display("FAIL rst_mid_after: ok=%0b aws=%0d beats=%0d err=%b required clean burst", ok, aw_obs.size(), w_obs.size(), err_o);
      end
   endtask

   task automatic test_random();
      bit ok;
      clear();
      rnd = 1;
      for (int i = 0; i < 10; i++) add_burst($urandom & 32'hFFFF_FFFC, 4'($urandom_range(0, 15)), 2'b00);
      drain(4000, ok);
      rnd = 0;
      checks++;
      if (!ok || aw_diff() != 0) begin
         errors++;
         $display("FAIL rand_aw: ok=%0b aws=%0d diffs=%0d required %0d matching AWs", ok, aw_obs.size(), aw_diff(), exp_aw.size());
      end
      checks++;
      if (w_diff() != 0 || data_pops != exp_w.size() || meta_pops != exp_aw.size()) begin
         errors++;
         $display("FAIL rand_w: beats=%0d diffs=%0d pops=%0d/%0d required %0d/%0d", w_obs.size(), w_diff(),
                  data_pops, meta_pops, exp_w.size(), exp_aw.size());
      end
      checks++;
      if (viol != 0 || err_o !== 1'b0) begin
         errors++;
         $display("FAIL rand_handshake: valid drops/changes while stalled=%0d err=%b required 0 0", viol, err_o);
      end
   endtask

   initial begin
      test_reset();
      test_single_burst();
      test_len0();
      test_data_stall();
      test_outstanding();
      test_bresp_err();
      test_reset_mid();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: simulation exceeded time limit, required completion");
      $fatal(1);
   end
endmodule
